vram_write_scheduler: RTL and testbench

VRAM_WRITE_SCHEDULER -- requirements
Module: vram_write_scheduler

---
 rtl/vram_pkg.sv | 15 +
 rtl/vram_rr_arb2.sv | 33 +++
 rtl/vram_write_scheduler.sv | 160 ++++++++++++++++
 tb/tb_vram_write_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM write scheduler: FSM state encoding and
// default geometry of the 160x120 one-bit frame buffer.
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W  = 20;
    localparam int unsigned VRAM_NUM_PIX = 19200;
    localparam int unsigned VRAM_ROW     = 160;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } vram_state_e;

endpackage

// File: rtl/vram_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from the request pair
// and the remembered last winner; the winner is recorded only when the caller
// accepts the grant via 'update'. Grant bit 0 is requester A, bit 1 is B.
module vram_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_b;

    // Tie goes to whoever did not win last; a lone request always wins.
    always_comb begin
        grant = '0;
        if (req == 2'b11) begin
            grant = last_b ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    // Remember the accepted winner; reset leaves B as last so A wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_b <= 1'b1;
        end else if (update) begin
            last_b <= grant[1];
        end
    end

endmodule

// File: rtl/vram_write_scheduler.sv
// VRAM write scheduler: arbitrates two pixel-write requesters onto a single
// VRAM write port and, optionally, sweeps the whole buffer to zero.
// Optional clear engine is enabled by defining VRAM_SCHED_CLEAR_EN; without
// it clear_start is ignored and clear_busy/clear_done read 0.
module vram_write_scheduler
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W  = VRAM_ADDR_W,
    parameter int unsigned NUM_PIX = VRAM_NUM_PIX
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_data,
    output logic              a_ack,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_data,
    output logic              b_ack,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] write_addr,
    output logic              wdata,
    output logic              write_en,
    output logic              oob
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIX - 1);

    vram_state_e       state;
    logic [1:0]        grant;
    logic              any_req;
    logic              clear_go;
    logic              arb_update;
    logic [ADDR_W-1:0] win_addr;
    logic              win_data;
    logic              win_oob;

    assign any_req    = a_req | b_req;
    assign arb_update = (state == ST_IDLE) && !clear_go && any_req;

    vram_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({b_req, a_req}),
        .update  (arb_update),
        .grant   (grant)
    );

    // Select the winning requester's address and pixel value.
    always_comb begin
        win_addr = a_addr;
        win_data = a_data;
        if (grant[1]) begin
            win_addr = b_addr;
            win_data = b_data;
        end
        win_oob = (win_addr > LAST_PIX);
    end

`ifdef VRAM_SCHED_CLEAR_EN
    logic              clear_pend;
    logic [ADDR_W-1:0] clr_cnt;

    // A pulse seen in IDLE counts as pending straight away, so it takes the
    // same decision edge rather than waiting one extra cycle.
    assign clear_go = clear_pend | clear_start;
`else
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign clear_go           = 1'b0;
    assign clear_busy         = 1'b0;
    assign clear_done         = 1'b0;
`endif

    // Scheduler FSM; every output is a register updated on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            write_addr <= '0;
            wdata      <= 1'b0;
            write_en   <= 1'b0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            oob        <= 1'b0;
`ifdef VRAM_SCHED_CLEAR_EN
            clear_pend <= 1'b0;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef VRAM_SCHED_CLEAR_EN
                    if (clear_go) begin
                        state      <= ST_CLEAR;
                        clear_pend <= 1'b0;
                        clr_cnt    <= '0;
                        write_addr <= '0;
                        wdata      <= 1'b0;
                        write_en   <= 1'b1;
                        clear_busy <= 1'b1;
                        clear_done <= (LAST_PIX == '0);
                    end else
`endif
                    if (any_req) begin
                        state      <= ST_WRITE;
                        write_addr <= win_addr;
                        wdata      <= win_data;
                        write_en   <= !win_oob;
                        oob        <= win_oob;
                        a_ack      <= grant[0];
                        b_ack      <= grant[1];
                    end
                end

                ST_WRITE: begin
                    state    <= ST_IDLE;
                    write_en <= 1'b0;
                    a_ack    <= 1'b0;
                    b_ack    <= 1'b0;
                    oob      <= 1'b0;
`ifdef VRAM_SCHED_CLEAR_EN
                    if (clear_start) begin
                        clear_pend <= 1'b1;
                    end
`endif
                end

`ifdef VRAM_SCHED_CLEAR_EN
                ST_CLEAR: begin
                    if (clr_cnt == LAST_PIX) begin
                        state      <= ST_IDLE;
                        write_en   <= 1'b0;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b0;
                    end else begin
                        clr_cnt    <= clr_cnt + 1'b1;
                        write_addr <= clr_cnt + 1'b1;
                        clear_done <= ((clr_cnt + 1'b1) == LAST_PIX);
                    end
                end
`endif

                default: begin
                    state    <= ST_IDLE;
                    write_en <= 1'b0;
                    a_ack    <= 1'b0;
                    b_ack    <= 1'b0;
                    oob      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed testbench for vram_write_scheduler. Inputs change and outputs are
// sampled on the falling edge; the design acts on the rising edge.
module tb_vram_write_scheduler;

    localparam int unsigned AW = 20;
    localparam int unsigned NP = 19200;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          a_req, b_req, a_data, b_data, clear_start;
    logic [AW-1:0] a_addr, b_addr;
    logic          a_ack, b_ack, clear_busy, clear_done;
    logic [AW-1:0] write_addr;
    logic          wdata, write_en, oob;

    int checks = 0;
    int errors = 0;

    vram_write_scheduler #(.ADDR_W(AW), .NUM_PIX(NP)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .a_req       (a_req),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .a_ack       (a_ack),
        .b_req       (b_req),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .b_ack       (b_ack),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .write_addr  (write_addr),
        .wdata       (wdata),
        .write_en    (write_en),
        .oob         (oob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // {write_en, a_ack, b_ack, oob, clear_busy, clear_done}
    function automatic logic [31:0] flags();
        return {26'd0, write_en, a_ack, b_ack, oob, clear_busy, clear_done};
    endfunction

    initial begin
        reset_n     = 1'b0;
        a_req       = 1'b0;
        b_req       = 1'b0;
        a_addr      = '0;
        b_addr      = '0;
        a_data      = 1'b0;
        b_data      = 1'b0;
        clear_start = 1'b0;

        // Reset state
        step();
        step();
        chk("reset_flags", flags(), 32'h0);
        chk("reset_addr", 32'(write_addr), 32'h0);
        chk("reset_wdata", 32'(wdata), 32'h0);
        reset_n = 1'b1;
        step();
        chk("idle_flags", flags(), 32'h0);

        // Single A write: addr 5, data 1
        a_req = 1'b1; a_addr = 20'd5; a_data = 1'b1;
        step();
        chk("a5_flags", flags(), 32'b110000);
        chk("a5_addr", 32'(write_addr), 32'd5);
        chk("a5_wdata", 32'(wdata), 32'd1);
        a_req = 1'b0;
        step();
        chk("a5_pulse_end", flags(), 32'h0);

        // Fresh reset, then both requesters held: A,B,A,B two cycles apart
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        a_req = 1'b1; a_addr = 20'd10; a_data = 1'b1;
        b_req = 1'b1; b_addr = 20'd20; b_data = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k % 2 == 1) begin
                if (k % 4 == 1) begin
                    chk($sformatf("rr%0d_flags", k), flags(), 32'b110000);
                    chk($sformatf("rr%0d_addr", k), 32'(write_addr), 32'd10);
                    chk($sformatf("rr%0d_wdata", k), 32'(wdata), 32'd1);
                end else begin
                    chk($sformatf("rr%0d_flags", k), flags(), 32'b101000);
                    chk($sformatf("rr%0d_addr", k), 32'(write_addr), 32'd20);
                    chk($sformatf("rr%0d_wdata", k), 32'(wdata), 32'd0);
                end
                if (k == 7) begin
                    a_req = 1'b0;
                    b_req = 1'b0;
                end
            end else begin
                chk($sformatf("rr%0d_gap", k), flags(), 32'h0);
            end
        end

        // Out-of-range B request: acked, flagged, not written
        b_req = 1'b1; b_addr = 20'd19200; b_data = 1'b1;
        step();
        chk("oob_flags", flags(), 32'b001100);
        b_req = 1'b0;
        step();
        chk("oob_pulse_end", flags(), 32'h0);

        // Last valid cell is written normally
        a_req = 1'b1; a_addr = 20'd19199; a_data = 1'b1;
        step();
        chk("last_flags", flags(), 32'b110000);
        chk("last_addr", 32'(write_addr), 32'd19199);
        a_req = 1'b0;
        step();

`ifdef VRAM_SCHED_CLEAR_EN
        // Full clear with A held; A is served once the sweep is over
        clear_start = 1'b1;
        a_req = 1'b1; a_addr = 20'd7; a_data = 1'b1;
        for (int i = 0; i < int'(NP); i++) begin
            step();
            clear_start = 1'b0;
            chk($sformatf("clr%0d", i),
                {flags(), 12'd0} | 32'(write_addr) | (32'(wdata) << 20),
                {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, (i == int'(NP) - 1), 12'd0} | 32'(i));
        end
        step();
        chk("clr_after_flags", flags(), 32'h0);
        step();
        chk("clr_then_a_flags", flags(), 32'b110000);
        chk("clr_then_a_addr", 32'(write_addr), 32'd7);
        a_req = 1'b0;
        step();

        // Pulse during WRITE becomes pending and beats B; reset aborts at count 100
        a_req = 1'b1; a_addr = 20'd4; a_data = 1'b1;
        step();
        chk("pend_a_flags", flags(), 32'b110000);
        a_req = 1'b0;
        clear_start = 1'b1;
        b_req = 1'b1; b_addr = 20'd6; b_data = 1'b1;
        step();
        clear_start = 1'b0;
        chk("pend_idle_flags", flags(), 32'h0);
        step();
        chk("pend_clear_flags", flags(), 32'b100010);
        chk("pend_clear_addr", 32'(write_addr), 32'd0);
        for (int j = 0; j < 100; j++) step();
        chk("abort_pre_addr", 32'(write_addr), 32'd100);
        chk("abort_pre_flags", flags(), 32'b100010);
        reset_n = 1'b0;
        b_req = 1'b0;
        #1;
        chk("abort_now_flags", flags(), 32'h0);
        step();
        reset_n = 1'b1;
        step();
        chk("abort_idle_flags", flags(), 32'h0);
        a_req = 1'b1; a_addr = 20'd3; a_data = 1'b0;
        step();
        chk("abort_serve_flags", flags(), 32'b110000);
        chk("abort_serve_addr", 32'(write_addr), 32'd3);
        a_req = 1'b0;
        step();
`else
        // Clear engine absent: clear_start has no effect, requests still served
        clear_start = 1'b1;
        a_req = 1'b1; a_addr = 20'd9; a_data = 1'b1;
        step();
        clear_start = 1'b0;
        chk("noclr_flags", flags(), 32'b110000);
        chk("noclr_addr", 32'(write_addr), 32'd9);
        a_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            chk($sformatf("noclr_idle%0d", j), flags(), 32'h0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
